apb_reg_completer: RTL and testbench

//  APB4 completer (responder) with a register bank, for the APB side of the AHB-to-APB bridge.

---
 rtl/apb_reg_completer.sv | 151 +++++++++++++++
 tb/tb_apb_reg_completer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_completer.sv
// APB4 completer with a small register bank for the APB side of the AHB-to-APB bridge.
// Decodes one window, inserts programmable wait states, honours PSTRB and filters on PPROT.
module apb_reg_completer #(
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001,
  parameter bit          SECURE_ONLY = 1'b1,
  parameter bit          PRIV_ONLY   = 1'b0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [31:0]             PADDR,
  input  logic                    PWRITE,
  input  logic [31:0]             PWDATA,
  input  logic [3:0]              PSTRB,
  input  logic [2:0]              PPROT,
  output logic [31:0]             PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [32*NUM_REGS-1:0]  reg_q,
  output logic                    err_pulse
);

  // state  | meaning
  // IDLE   | no transfer in flight; a SETUP phase latches the request
  // ACCESS | wait-state countdown, then completion while PENABLE is high

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [IDX_W-1:0]  idx_q;
  logic              err_q;
  logic              err_pulse_q;
  logic [31:0]       bank_q [1:NUM_REGS-1];

  logic [31:0]       offset;
  logic              in_range;
  logic              misaligned;
  logic              prot_err;
  logic              ro_err;
  logic              setup_err;
  logic [IDX_W-1:0]  setup_idx;
  logic              ready;
  logic              complete;
  logic [31:0]       rd_mux;
  logic              unused_ok;

  // Full 32-bit offset: addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  assign offset     = PADDR - BASE_ADDR;
  assign in_range   = offset[31:2] < 30'(NUM_REGS);
  assign misaligned = PADDR[1:0] != 2'b00;
  assign prot_err   = (SECURE_ONLY && PPROT[1]) || (PRIV_ONLY && !PPROT[0]);
  assign setup_idx  = offset[IDX_W+1:2];
  assign ro_err     = PWRITE && (setup_idx == '0);
  assign setup_err  = !in_range || misaligned || prot_err || ro_err;
  assign unused_ok  = ^{PPROT[2], offset[1:0]};

  // A dropped PSEL in ACCESS is an abort, so PREADY is held low rather than completing.
  assign ready    = (state_q == ACCESS) && (cnt_q == 4'd0) && PSEL;
  assign complete = ready && PENABLE;

  assign PREADY    = ready;
  assign PSLVERR   = ready && err_q;
  assign PRDATA    = (ready && !wr_q && !err_q) ? rd_mux : 32'h0;
  assign err_pulse = err_pulse_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      wdata_q     <= 32'h0;
      strb_q      <= 4'h0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= complete && err_q;
      case (state_q)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            wr_q    <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            idx_q   <= setup_idx;
            err_q   <= setup_err;
            cnt_q   <= 4'(WAIT_STATES);
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state_q <= IDLE;
          end else if (PENABLE) begin
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int k = 1; k < int'(NUM_REGS); k++) begin
        bank_q[k] <= 32'h0;
      end
    end else if (complete && wr_q && !err_q) begin
      for (int k = 1; k < int'(NUM_REGS); k++) begin
        if (idx_q == IDX_W'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (strb_q[b]) begin
              bank_q[k][8*b +: 8] <= wdata_q[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    rd_mux = ID_VALUE;
    for (int k = 1; k < int'(NUM_REGS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        rd_mux = bank_q[k];
      end
    end
  end

  assign reg_q[31:0] = ID_VALUE;
  for (genvar k = 1; k < NUM_REGS; k++) begin : g_flat
    assign reg_q[32*k +: 32] = bank_q[k];
  end

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: one instance with one wait state, one with none,
// checked every cycle against a register-array model plus literal expectations.
module tb_apb_reg_completer;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] ID   = 32'hA5B0_0001;
  localparam int          NREG = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: WAIT_STATES=1 instance, index 1: WAIT_STATES=0 instance
  logic              psel    [2];
  logic              penable [2];
  logic [31:0]       paddr   [2];
  logic              pwrite  [2];
  logic [31:0]       pwdata  [2];
  logic [3:0]        pstrb   [2];
  logic [2:0]        pprot   [2];
  logic [31:0]       prdata  [2];
  logic              pready  [2];
  logic              pslverr [2];
  logic [32*NREG-1:0] regq   [2];
  logic              epulse  [2];

  apb_reg_completer #(.NUM_REGS(NREG), .BASE_ADDR(BASE), .WAIT_STATES(1), .ID_VALUE(ID),
                      .SECURE_ONLY(1'b1), .PRIV_ONLY(1'b0)) u_dut_ws1 (
    .HCLK(clk), .HRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]), .PADDR(paddr[0]),
    .PWRITE(pwrite[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PPROT(pprot[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .reg_q(regq[0]),
    .err_pulse(epulse[0]));

  apb_reg_completer #(.NUM_REGS(NREG), .BASE_ADDR(BASE), .WAIT_STATES(0), .ID_VALUE(ID),
                      .SECURE_ONLY(1'b1), .PRIV_ONLY(1'b0)) u_dut_ws0 (
    .HCLK(clk), .HRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]), .PADDR(paddr[1]),
    .PWRITE(pwrite[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PPROT(pprot[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .reg_q(regq[1]),
    .err_pulse(epulse[1]));

  int errors = 0;
  int checks = 0;

  // transfer currently presented on each bus: phase 0 idle, 1 setup, 2 access
  int          phase  [2];
  int          acc_n  [2];
  logic        cur_wr [2];
  logic [31:0] cur_a  [2];
  logic [31:0] cur_w  [2];
  logic [3:0]  cur_s  [2];
  logic [2:0]  cur_p  [2];
  logic [31:0] model  [2][NREG];
  logic        pend   [2];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic spec_err(input logic wr, input logic [31:0] a, input logic [2:0] p);
    logic [31:0] off;
    off = a - BASE;
    return (off >= 32'(4*NREG)) || (a[1:0] != 2'b00) || p[1] || (wr && off == 32'h0);
  endfunction

  function automatic logic [32*NREG-1:0] flat(input int d);
    logic [32*NREG-1:0] f;
    f[31:0] = ID;
    for (int k = 1; k < NREG; k++) f[32*k +: 32] = model[d][k];
    return f;
  endfunction

  logic        exp_rdy;
  logic        exp_e;
  logic [31:0] exp_rd;
  int          ws;
  int          idx;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ws = (d == 0) ? 1 : 0;
      if (!rst_n) begin
        for (int k = 1; k < NREG; k++) model[d][k] = 32'h0;
        pend[d] = 1'b0;
        chk("rst_pready", pready[d], 0);
        chk("rst_pslverr", pslverr[d], 0);
        chk("rst_prdata", prdata[d], 0);
        chk("rst_err_pulse", epulse[d], 0);
        chk("rst_reg_q", regq[d], flat(d));
      end else begin
        chk("err_pulse", epulse[d], pend[d]);
        chk("reg_q", regq[d], flat(d));
        exp_rdy = (phase[d] == 2) && (acc_n[d] > ws);
        exp_e   = spec_err(cur_wr[d], cur_a[d], cur_p[d]);
        idx     = int'((cur_a[d] - BASE) >> 2);
        exp_rd  = 32'h0;
        if (exp_rdy && !cur_wr[d] && !exp_e) exp_rd = (idx == 0) ? ID : model[d][idx];
        chk("pready", pready[d], exp_rdy);
        chk("pslverr", pslverr[d], exp_rdy && exp_e);
        chk("prdata", prdata[d], exp_rd);
        pend[d] = exp_rdy && exp_e;
        if (exp_rdy && cur_wr[d] && !exp_e)
          for (int b = 0; b < 4; b++)
            if (cur_s[d][b]) model[d][idx][8*b +: 8] = cur_w[d][8*b +: 8];
      end
    end
  end

  // Entered and left just after a rising edge with the bus idle, so calls chain back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] w,
                      input logic [3:0] s, input logic [2:0] p, input int abort_at,
                      input bit scramble, output logic [31:0] rd, output logic err,
                      output int lat);
    bit done;
    rd = 32'h0; err = 1'b0; lat = 0; done = 1'b0;
    psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = a; pwrite[d] = wr;
    pwdata[d] = w; pstrb[d] = s; pprot[d] = p;
    cur_wr[d] = wr; cur_a[d] = a; cur_w[d] = w; cur_s[d] = s; cur_p[d] = p;
    phase[d] = 1; acc_n[d] = 0;
    @(posedge clk); #1;
    penable[d] = 1'b1; phase[d] = 2; acc_n[d] = 1;
    if (scramble) begin
      paddr[d] = a ^ 32'h0000_0004; pwdata[d] = ~w; pstrb[d] = 4'hF;
    end
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge clk);
      if (pready[d]) begin
        rd = prdata[d]; err = pslverr[d]; lat = n; done = 1'b1;
      end
      @(posedge clk); #1;
      if (done) begin
        psel[d] = 1'b0; penable[d] = 1'b0; phase[d] = 0;
      end else if (abort_at == n) begin
        psel[d] = 1'b0; penable[d] = 1'b0; phase[d] = 0; done = 1'b1;
        @(posedge clk); #1;
      end else begin
        acc_n[d]++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: got no PREADY within 20 cycles, required completion");
      psel[d] = 1'b0; penable[d] = 1'b0; phase[d] = 0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; paddr[d] = 0; pwrite[d] = 0; pwdata[d] = 0;
      pstrb[d] = 0; pprot[d] = 0; phase[d] = 0; acc_n[d] = 0; cur_wr[d] = 0;
      cur_a[d] = BASE; cur_w[d] = 0; cur_s[d] = 0; cur_p[d] = 0; pend[d] = 0;
      for (int k = 0; k < NREG; k++) model[d][k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("id_after_reset", regq[0][31:0], ID);
    chk("rw_after_reset", regq[0][255:32], 0);
    @(posedge clk); #1;

    xfer(0, 1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 3'b001, 0, 0, rd, er, lat);
    chk("w1_latency", lat, 2);
    chk("w1_slverr", er, 0);
    @(negedge clk);
    chk("w1_reg1", regq[0][63:32], 32'hDEAD_BEEF);
    @(posedge clk); #1;

    xfer(0, 1, 32'h8000_0004, 32'h0000_1200, 4'b0010, 3'b001, 0, 0, rd, er, lat);
    xfer(0, 0, 32'h8000_0004, 32'h0, 4'hF, 3'b001, 0, 0, rd, er, lat);
    chk("strb_read_reg1", rd, 32'hDEAD_12EF);

    xfer(0, 0, BASE, 32'h0, 4'h0, 3'b001, 0, 0, rd, er, lat);
    chk("id_read", rd, ID);
    chk("id_read_slverr", er, 0);

    xfer(0, 1, BASE, 32'h1234_5678, 4'hF, 3'b001, 0, 0, rd, er, lat);
    chk("ro_write_slverr", er, 1);
    @(negedge clk);
    chk("ro_write_pulse", epulse[0], 1);
    chk("ro_write_reg0", regq[0][31:0], ID);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ro_write_pulse_end", epulse[0], 0);
    @(posedge clk); #1;

    xfer(0, 0, 32'h8000_0020, 32'h0, 4'h0, 3'b001, 0, 0, rd, er, lat);
    chk("oor_slverr", er, 1);
    chk("oor_prdata", rd, 0);
    xfer(0, 0, 32'h8000_0006, 32'h0, 4'h0, 3'b001, 0, 0, rd, er, lat);
    chk("misalign_slverr", er, 1);
    xfer(0, 0, 32'h7FFF_FFFC, 32'h0, 4'h0, 3'b001, 0, 0, rd, er, lat);
    chk("below_base_slverr", er, 1);
    xfer(0, 0, 32'h8000_0004, 32'h0, 4'h0, 3'b010, 0, 0, rd, er, lat);
    chk("nonsec_read_slverr", er, 1);
    chk("nonsec_read_prdata", rd, 0);
    xfer(0, 1, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF, 3'b010, 0, 0, rd, er, lat);
    chk("nonsec_write_slverr", er, 1);
    @(negedge clk);
    chk("nonsec_write_reg1", regq[0][63:32], 32'hDEAD_12EF);
    @(posedge clk); #1;

    xfer(0, 1, 32'h8000_0008, 32'hFFFF_FFFF, 4'h0, 3'b001, 0, 0, rd, er, lat);
    chk("strb0_slverr", er, 0);
    xfer(0, 1, 32'h8000_000C, 32'h1122_3344, 4'hF, 3'b001, 0, 1, rd, er, lat);
    xfer(0, 0, 32'h8000_000C, 32'h0, 4'h0, 3'b001, 0, 0, rd, er, lat);
    chk("scramble_reg3", rd, 32'h1122_3344);

    xfer(0, 1, 32'h8000_0008, 32'hCAFE_F00D, 4'hF, 3'b001, 1, 0, rd, er, lat);
    xfer(0, 0, 32'h8000_0008, 32'h0, 4'h0, 3'b001, 0, 0, rd, er, lat);
    chk("abort_reg2", rd, 0);
    chk("abort_then_latency", lat, 2);

    // reset in the middle of an ACCESS phase
    psel[0] = 1; penable[0] = 0; paddr[0] = 32'h8000_0008; pwrite[0] = 1;
    pwdata[0] = 32'h5555_AAAA; pstrb[0] = 4'hF; pprot[0] = 3'b001;
    cur_wr[0] = 1; cur_a[0] = 32'h8000_0008; cur_w[0] = 32'h5555_AAAA;
    cur_s[0] = 4'hF; cur_p[0] = 3'b001; phase[0] = 1; acc_n[0] = 0;
    @(posedge clk); #1;
    penable[0] = 1; phase[0] = 2; acc_n[0] = 1;
    @(posedge clk); #1;
    rst_n = 1'b0; psel[0] = 0; penable[0] = 0; phase[0] = 0;
    @(negedge clk);
    chk("midreset_regs", regq[0], {224'h0, ID});
    chk("midreset_pready", pready[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(1, 1, 32'h8000_0004, 32'h1111_1111, 4'hF, 3'b001, 0, 0, rd, er, lat);
    chk("b2b_lat1", lat, 1);
    xfer(1, 1, 32'h8000_0008, 32'h2222_2222, 4'hF, 3'b001, 0, 0, rd, er, lat);
    chk("b2b_lat2", lat, 1);
    xfer(1, 1, 32'h8000_000C, 32'h3333_3333, 4'hF, 3'b001, 0, 0, rd, er, lat);
    chk("b2b_lat3", lat, 1);
    xfer(1, 1, 32'h8000_0004, 32'h4444_4444, 4'hF, 3'b001, 0, 0, rd, er, lat);
    chk("b2b_lat4", lat, 1);
    @(negedge clk);
    chk("b2b_regs", regq[1][127:32], {32'h3333_3333, 32'h2222_2222, 32'h4444_4444});
    @(posedge clk); #1;
    xfer(1, 1, BASE, 32'hFFFF_FFFF, 4'hF, 3'b001, 0, 0, rd, er, lat);
    chk("b2b_ro_slverr", er, 1);
    xfer(1, 0, 32'h8000_0004, 32'h0, 4'h0, 3'b001, 0, 0, rd, er, lat);
    chk("b2b_read_reg1", rd, 32'h4444_4444);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
